// File: rtl/rxectrl.sv
// rtl/rxectrl.sv - Ethernet RX controller: byte-rate clock enable, boundary-safe config apply, frame/runt counters
module rxectrl #(
    parameter int GAP_BEATS = 4,
    parameter int MIN_BEATS = 64
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cfg_wr,
    input  logic [3:0]  i_cfg_data,
    input  logic        i_rx_v,
    output logic        o_ce,
    output logic        o_pre_en,
    output logic        o_crc_en,
    output logic        o_busy,
    output logic        o_cfg_pending,
    output logic [15:0] o_frames,
    output logic [15:0] o_runts
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP} state_t;

    localparam logic [15:0] GAP_B = 16'(GAP_BEATS);
    localparam logic [15:0] MIN_B = 16'(MIN_BEATS);

    state_t      state, state_next;
    logic [6:0]  div, div_next;
    logic [1:0]  spd;
    logic [3:0]  pend_data, apply_data;
    logic        apply;
    logic [15:0] beats, beats_next;
    logic [15:0] gap, gap_next;
    logic [15:0] frames_next, runts_next;

    function automatic logic [6:0] reload(input logic [1:0] s);
        case (s)
            2'b00:   return 7'd99;
            2'b01:   return 7'd9;
            default: return 7'd0;
        endcase
    endfunction

    always_comb begin
        // Config may only take effect between frames; a same-cycle write supersedes the pending value.
        apply       = (state == ST_IDLE) && !i_rx_v && o_cfg_pending;
        apply_data  = i_cfg_wr ? i_cfg_data : pend_data;
        state_next  = state;
        beats_next  = beats;
        gap_next    = gap;
        frames_next = o_frames;
        runts_next  = o_runts;

        if (o_ce) begin
            case (state)
                ST_IDLE: begin
                    if (i_rx_v) begin
                        state_next = ST_ACTIVE;
                        beats_next = 16'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (i_rx_v) begin
                        if (beats != 16'hFFFF)
                            beats_next = beats + 16'd1;
                    end else begin
                        state_next  = ST_GAP;
                        frames_next = o_frames + 16'd1;
                        if (beats < MIN_B)
                            runts_next = o_runts + 16'd1;
                        gap_next = 16'd1;
                    end
                end
                ST_GAP: begin
                    if (i_rx_v) begin
                        state_next = ST_ACTIVE;
                        beats_next = 16'd1;
                    end else if (gap == GAP_B) begin
                        state_next = ST_IDLE;
                    end else begin
                        gap_next = gap + 16'd1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        // A speed change restarts the divider so the new rate begins with an enable.
        if (apply && (apply_data[3:2] != spd))
            div_next = 7'd0;
        else if (div == 7'd0)
            div_next = reload(spd);
        else
            div_next = div - 7'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= ST_IDLE;
            div           <= 7'd0;
            spd           <= 2'b10;
            pend_data     <= 4'b1011;
            beats         <= 16'd0;
            gap           <= 16'd0;
            o_ce          <= 1'b0;
            o_pre_en      <= 1'b1;
            o_crc_en      <= 1'b1;
            o_busy        <= 1'b0;
            o_cfg_pending <= 1'b0;
            o_frames      <= 16'd0;
            o_runts       <= 16'd0;
        end else begin
            state    <= state_next;
            div      <= div_next;
            beats    <= beats_next;
            gap      <= gap_next;
            o_frames <= frames_next;
            o_runts  <= runts_next;
            o_ce     <= (div_next == 7'd0);
            o_busy   <= (state_next != ST_IDLE);
            if (i_cfg_wr)
                pend_data <= i_cfg_data;
            if (apply) begin
                o_pre_en      <= apply_data[0];
                o_crc_en      <= apply_data[1];
                spd           <= apply_data[3:2];
                o_cfg_pending <= 1'b0;
            end else if (i_cfg_wr) begin
                o_cfg_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rxectrl.sv
// tb/tb_rxectrl.sv - self-checking bench for rxectrl
module tb_rxectrl;
    localparam int GAP_BEATS = 4;
    localparam int MIN_BEATS = 64;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_cfg_wr = 1'b0;
    logic [3:0]  i_cfg_data = 4'd0;
    logic        i_rx_v = 1'b0;
    logic        o_ce, o_pre_en, o_crc_en, o_busy, o_cfg_pending;
    logic [15:0] o_frames, o_runts;

    always #5 i_clk = ~i_clk;

    rxectrl #(.GAP_BEATS(GAP_BEATS), .MIN_BEATS(MIN_BEATS)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cfg_wr(i_cfg_wr), .i_cfg_data(i_cfg_data),
        .i_rx_v(i_rx_v), .o_ce(o_ce), .o_pre_en(o_pre_en), .o_crc_en(o_crc_en),
        .o_busy(o_busy), .o_cfg_pending(o_cfg_pending), .o_frames(o_frames), .o_runts(o_runts)
    );

    int checks = 0;
    int errors = 0;

    // Reference: a frame is a run of ce-sampled valid beats; "quiet" counts idle ce-beats after a frame.
    bit       m_ce, m_pre, m_crc, m_busy, m_pend, m_in_frame;
    bit [1:0] m_spd;
    bit [3:0] m_pdata;
    int       m_frames, m_runts, m_len, m_quiet, m_age;

    function automatic int period(input bit [1:0] s);
        return (s == 2'b00) ? 100 : (s == 2'b01) ? 10 : 1;
    endfunction

    task automatic model_step();
        bit       ce0, apply;
        bit [3:0] ad;
        if (!i_reset_n) begin
            m_ce = 0; m_pre = 1; m_crc = 1; m_spd = 2'b10; m_pend = 0; m_pdata = 4'b1011;
            m_frames = 0; m_runts = 0; m_in_frame = 0; m_len = 0; m_quiet = 0; m_age = -1;
        end else begin
            ce0   = m_ce;
            apply = !m_in_frame && (m_quiet == 0) && !i_rx_v && m_pend;
            ad    = i_cfg_wr ? i_cfg_data : m_pdata;
            if (ce0) begin
                if (m_in_frame) begin
                    if (i_rx_v) begin
                        if (m_len < 65535) m_len++;
                    end else begin
                        m_frames = (m_frames + 1) % 65536;
                        if (m_len < MIN_BEATS) m_runts = (m_runts + 1) % 65536;
                        m_in_frame = 0;
                        m_quiet = 1;
                    end
                end else if (i_rx_v) begin
                    m_in_frame = 1; m_len = 1; m_quiet = 0;
                end else if (m_quiet > 0) begin
                    m_quiet++;
                    if (m_quiet > GAP_BEATS) m_quiet = 0;
                end
            end
            if (apply) begin
                m_pre = ad[0]; m_crc = ad[1];
                if (ad[3:2] != m_spd) m_age = -1;
                m_spd = ad[3:2];
                m_pend = 0;
            end else if (i_cfg_wr) begin
                m_pend = 1;
            end
            if (i_cfg_wr) m_pdata = i_cfg_data;
            m_age++;
            m_ce = (m_age % period(m_spd)) == 0;
        end
        m_busy = m_in_frame || (m_quiet > 0);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ce", 16'(o_ce), 16'(m_ce));
        chk("pre_en", 16'(o_pre_en), 16'(m_pre));
        chk("crc_en", 16'(o_crc_en), 16'(m_crc));
        chk("busy", 16'(o_busy), 16'(m_busy));
        chk("pending", 16'(o_cfg_pending), 16'(m_pend));
        chk("frames", o_frames, 16'(m_frames));
        chk("runts", o_runts, 16'(m_runts));
    endtask

    task automatic cyc(input logic wr, input logic [3:0] d, input logic rx, input logic rst_n);
        i_cfg_wr   = wr;
        i_cfg_data = d;
        i_rx_v     = rx;
        i_reset_n  = rst_n;
        @(posedge i_clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic frame(input int beats, input int wr_at, input logic [3:0] d);
        for (int i = 1; i <= beats; i++)
            cyc(i == wr_at, d, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int n;
        logic rx, rst_n;

        cyc(1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0);
        chk("rst_ce", 16'(o_ce), 16'd0);
        chk("rst_pre", 16'(o_pre_en), 16'd1);
        chk("rst_frames", o_frames, 16'd0);
        idle(5);
        chk("gig_ce", 16'(o_ce), 16'd1);

        // Switch to 100M while idle.
        cyc(1'b1, 4'b0100, 1'b0, 1'b1);
        chk("wr_pending", 16'(o_cfg_pending), 16'd1);
        idle(1);
        chk("apply_pending", 16'(o_cfg_pending), 16'd0);
        chk("apply_ce", 16'(o_ce), 16'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            n += int'(o_ce);
        end
        chk("ce_100m_count", 16'(n), 16'd2);

        // Back to 1G, then a 100-beat frame with a config write mid-frame.
        cyc(1'b1, 4'b1011, 1'b0, 1'b1);
        idle(3);
        frame(100, 50, 4'b1000);
        chk("frame_pre_hold", 16'(o_pre_en), 16'd1);
        chk("frame_pending", 16'(o_cfg_pending), 16'd1);
        for (int k = 1; k <= 7; k++) begin
            idle(1);
            if (k == 5) chk("pre_before_apply", 16'(o_pre_en), 16'd1);
            if (k == 6) chk("pre_applied", 16'(o_pre_en), 16'd0);
        end
        chk("frames_1", o_frames, 16'd1);
        chk("runts_0", o_runts, 16'd0);

        // Runt boundary: 63 beats is a runt, 64 is not.
        cyc(1'b0, 4'd0, 1'b0, 1'b0);
        frame(63, 0, 4'd0);
        idle(8);
        frame(64, 0, 4'd0);
        idle(8);
        chk("runts_boundary", o_runts, 16'd1);
        chk("frames_boundary", o_frames, 16'd2);

        // Back-to-back frames restarting inside the gap: no apply, busy held.
        frame(70, 10, 4'b1001);
        idle(2);
        chk("gap_busy", 16'(o_busy), 16'd1);
        chk("gap_pending", 16'(o_cfg_pending), 16'd1);
        frame(70, 0, 4'd0);
        chk("b2b_pre", 16'(o_pre_en), 16'd1);
        idle(8);
        chk("b2b_frames", o_frames, 16'd4);
        chk("b2b_pre_applied", 16'(o_pre_en), 16'd1);
        chk("b2b_crc_applied", 16'(o_crc_en), 16'd0);

        // Reset mid-frame.
        frame(30, 0, 4'd0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        chk("midrst_frames", o_frames, 16'd0);
        chk("midrst_busy", 16'(o_busy), 16'd0);
        chk("midrst_crc", 16'(o_crc_en), 16'd1);
        chk("midrst_ce", 16'(o_ce), 16'd0);

        // Randomized traffic, config writes and occasional resets.
        rx = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) rx = ~rx;
            rst_n = ($urandom_range(0, 799) != 0);
            cyc($urandom_range(0, 39) == 0, 4'($urandom), rx, rst_n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
